// File: rtl/main_bus_fabric.sv
// Single-master bus fabric: decodes a master read/write request onto one of
// two slaves, waits for the slave acknowledge (bounded by a timeout), checks
// even parity on both directions and returns a one-cycle completion strobe
// with error flags. Every output is a flop.
module main_bus_fabric #(
    parameter int unsigned                DATA_BUS_WIDTH = 32,
    parameter int unsigned                ADDR_BUS_WIDTH = 8,
    parameter logic [ADDR_BUS_WIDTH-1:0]  SLAVE0_ID      = 8'h01,
    parameter logic [ADDR_BUS_WIDTH-1:0]  SLAVE1_ID      = 8'h02,
    parameter int unsigned                TIMEOUT        = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      m_rb,
    input  logic                      m_wb,
    input  logic [ADDR_BUS_WIDTH-1:0] m_addr,
    input  logic [DATA_BUS_WIDTH-1:0] m_wdata,
    input  logic                      m_wparity,
    output logic                      m_ack,
    output logic [DATA_BUS_WIDTH-1:0] m_rdata,
    output logic                      m_rparity,
    output logic                      m_perr,
    output logic                      m_derr,
    output logic                      m_terr,
    output logic [ADDR_BUS_WIDTH-1:0] s_addr,
    output logic [DATA_BUS_WIDTH-1:0] s_wdata,
    output logic                      s_wparity,
    output logic [1:0]                s_rb,
    output logic [1:0]                s_wb,
    input  logic [1:0]                s_ack,
    input  logic [DATA_BUS_WIDTH-1:0] s0_rdata,
    input  logic [DATA_BUS_WIDTH-1:0] s1_rdata,
    input  logic                      s0_rparity,
    input  logic                      s1_rparity
);

    localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        RELEASE
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      sel_q, sel_d;
    logic                      is_read_q, is_read_d;

    // Completion status gathered in IDLE/ACCESS and presented in RESP.
    logic                      pend_perr_q, pend_perr_d;
    logic                      pend_derr_q, pend_derr_d;
    logic                      pend_terr_q, pend_terr_d;
    logic                      pend_rvalid_q, pend_rvalid_d;
    logic [DATA_BUS_WIDTH-1:0] pend_rdata_q, pend_rdata_d;
    logic                      pend_rparity_q, pend_rparity_d;

    logic                      m_ack_d, m_perr_d, m_derr_d, m_terr_d;
    logic [DATA_BUS_WIDTH-1:0] m_rdata_d;
    logic                      m_rparity_d;
    logic [ADDR_BUS_WIDTH-1:0] s_addr_d;
    logic [DATA_BUS_WIDTH-1:0] s_wdata_d;
    logic                      s_wparity_d;
    logic [1:0]                s_rb_d, s_wb_d;

    logic                      hit0, hit1, sel_ack;
    logic [DATA_BUS_WIDTH-1:0] sel_rdata;
    logic                      sel_rparity;

    assign hit0        = (m_addr == SLAVE0_ID);
    assign hit1        = (m_addr == SLAVE1_ID);
    assign sel_ack     = s_ack[sel_q];
    assign sel_rdata   = sel_q ? s1_rdata : s0_rdata;
    assign sel_rparity = sel_q ? s1_rparity : s0_rparity;

    // Next-state and next-output logic; flags and m_ack default low so they
    // can only be high in the cycle following RESP.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        is_read_d      = is_read_q;
        pend_perr_d    = pend_perr_q;
        pend_derr_d    = pend_derr_q;
        pend_terr_d    = pend_terr_q;
        pend_rvalid_d  = pend_rvalid_q;
        pend_rdata_d   = pend_rdata_q;
        pend_rparity_d = pend_rparity_q;
        m_ack_d        = 1'b0;
        m_perr_d       = 1'b0;
        m_derr_d       = 1'b0;
        m_terr_d       = 1'b0;
        m_rdata_d      = m_rdata;
        m_rparity_d    = m_rparity;
        s_addr_d       = s_addr;
        s_wdata_d      = s_wdata;
        s_wparity_d    = s_wparity;
        s_rb_d         = s_rb;
        s_wb_d         = s_wb;

        unique case (state_q)
            IDLE: begin
                if (m_rb || m_wb) begin
                    pend_perr_d   = 1'b0;
                    pend_derr_d   = 1'b0;
                    pend_terr_d   = 1'b0;
                    pend_rvalid_d = 1'b0;
                    if (m_rb && m_wb) begin
                        pend_derr_d = 1'b1;
                        state_d     = RESP;
                    end else if (!hit0 && !hit1) begin
                        pend_derr_d = 1'b1;
                        state_d     = RESP;
                    end else if (m_wb && (m_wparity != ^m_wdata)) begin
                        pend_perr_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        sel_d       = hit1;
                        is_read_d   = m_rb;
                        s_addr_d    = m_addr;
                        s_wdata_d   = m_wdata;
                        s_wparity_d = m_wparity;
                        s_rb_d      = m_rb ? (hit1 ? 2'b10 : 2'b01) : '0;
                        s_wb_d      = m_wb ? (hit1 ? 2'b10 : 2'b01) : '0;
                        cnt_d       = '0;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    s_rb_d  = '0;
                    s_wb_d  = '0;
                    state_d = RESP;
                    if (is_read_q) begin
                        pend_rvalid_d = 1'b1;
                        if (sel_rparity != ^sel_rdata) begin
                            pend_perr_d    = 1'b1;
                            pend_rdata_d   = '0;
                            pend_rparity_d = 1'b0;
                        end else begin
                            pend_rdata_d   = sel_rdata;
                            pend_rparity_d = sel_rparity;
                        end
                    end
                end else if (cnt_q == TMO_LAST) begin
                    s_rb_d      = '0;
                    s_wb_d      = '0;
                    pend_terr_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                m_ack_d  = 1'b1;
                m_perr_d = pend_perr_q;
                m_derr_d = pend_derr_q;
                m_terr_d = pend_terr_q;
                if (pend_rvalid_q) begin
                    m_rdata_d   = pend_rdata_q;
                    m_rparity_d = pend_rparity_q;
                end
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!m_rb && !m_wb) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sel_q          <= 1'b0;
            is_read_q      <= 1'b0;
            pend_perr_q    <= 1'b0;
            pend_derr_q    <= 1'b0;
            pend_terr_q    <= 1'b0;
            pend_rvalid_q  <= 1'b0;
            pend_rdata_q   <= '0;
            pend_rparity_q <= 1'b0;
            m_ack          <= 1'b0;
            m_rdata        <= '0;
            m_rparity      <= 1'b0;
            m_perr         <= 1'b0;
            m_derr         <= 1'b0;
            m_terr         <= 1'b0;
            s_addr         <= '0;
            s_wdata        <= '0;
            s_wparity      <= 1'b0;
            s_rb           <= '0;
            s_wb           <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            is_read_q      <= is_read_d;
            pend_perr_q    <= pend_perr_d;
            pend_derr_q    <= pend_derr_d;
            pend_terr_q    <= pend_terr_d;
            pend_rvalid_q  <= pend_rvalid_d;
            pend_rdata_q   <= pend_rdata_d;
            pend_rparity_q <= pend_rparity_d;
            m_ack          <= m_ack_d;
            m_rdata        <= m_rdata_d;
            m_rparity      <= m_rparity_d;
            m_perr         <= m_perr_d;
            m_derr         <= m_derr_d;
            m_terr         <= m_terr_d;
            s_addr         <= s_addr_d;
            s_wdata        <= s_wdata_d;
            s_wparity      <= s_wparity_d;
            s_rb           <= s_rb_d;
            s_wb           <= s_wb_d;
        end
    end

endmodule

// File: tb/tb_main_bus_fabric.sv
// Directed bench for main_bus_fabric: stimulus pushes the expected completion
// into a queue, a negedge monitor pops and compares on every m_ack.
module tb_main_bus_fabric;

    logic        clock;
    logic        reset_n;
    logic        m_rb, m_wb;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic        m_wparity;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        m_rparity, m_perr, m_derr, m_terr;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_wparity;
    logic [1:0]  s_rb, s_wb, s_ack;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_rparity, s1_rparity;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        rparity;
        logic        perr;
        logic        derr;
        logic        terr;
    } exp_t;

    exp_t sb[$];

    // Bench-side model of the held read-data registers.
    logic [31:0] mdl_rdata   = '0;
    logic        mdl_rparity = 1'b0;

    main_bus_fabric #(
        .DATA_BUS_WIDTH(32),
        .ADDR_BUS_WIDTH(8),
        .SLAVE0_ID(8'h01),
        .SLAVE1_ID(8'h02),
        .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .m_rb(m_rb), .m_wb(m_wb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wparity(m_wparity), .m_ack(m_ack), .m_rdata(m_rdata),
        .m_rparity(m_rparity), .m_perr(m_perr), .m_derr(m_derr),
        .m_terr(m_terr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wparity(s_wparity), .s_rb(s_rb), .s_wb(s_wb), .s_ack(s_ack),
        .s0_rdata(s0_rdata), .s1_rdata(s1_rdata),
        .s0_rparity(s0_rparity), .s1_rparity(s1_rparity)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic perr, input logic derr, input logic terr);
        exp_t e;
        e.name    = name;
        e.rdata   = mdl_rdata;
        e.rparity = mdl_rparity;
        e.perr    = perr;
        e.derr    = derr;
        e.terr    = terr;
        sb.push_back(e);
    endtask

    // Monitor: completion checks against the scoreboard plus per-cycle
    // invariants (flags low without m_ack, at most one strobe bit).
    always @(negedge clock) begin
        exp_t e;
        if (m_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_resp"},
                    {29'd0, m_rdata, m_rparity, m_perr, m_derr, m_terr},
                    {29'd0, e.rdata, e.rparity, e.perr, e.derr, e.terr});
            end
        end else begin
            chk("flags_idle", {61'd0, m_perr, m_derr, m_terr}, 64'd0);
        end
        chk("strobe_onehot", 64'($countones({s_rb, s_wb}) > 1), 64'd0);
    end

    task automatic start(input logic rb, input logic wb, input logic [7:0] addr,
                         input logic [31:0] wd, input logic wp);
        m_rb      = rb;
        m_wb      = wb;
        m_addr    = addr;
        m_wdata   = wd;
        m_wparity = wp;
    endtask

    // Wait (bounded) for m_ack, then drop the request and let RELEASE exit.
    task automatic wait_ack(input string name, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (m_ack) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk({name, "_ack_timeout"}, 64'd0, 64'd1);
        m_rb = 1'b0;
        m_wb = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        int lat;
        int n;
        reset_n = 1'b0;
        start(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        s_ack = '0;
        s0_rdata = '0; s1_rdata = '0; s0_rparity = 1'b0; s1_rparity = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_outs",
            {m_ack, m_rdata, m_rparity, m_perr, m_derr, m_terr, s_addr,
             s_wparity, s_rb, s_wb, 13'd0},
            64'd0);
        chk("reset_swdata", {32'd0, s_wdata}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Write to slave 0, acked on the first ACCESS cycle (minimum latency).
        start(1'b0, 1'b1, 8'h01, 32'h1, 1'b1);
        push("wr_s0", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("wr_s0_strobe", {60'd0, s_rb, s_wb}, {60'd0, 2'b00, 2'b01});
        chk("wr_s0_latch", {23'd0, s_addr, s_wdata, s_wparity}, {23'd0, 8'h01, 32'h1, 1'b1});
        s_ack = 2'b01;
        @(negedge clock);
        s_ack = 2'b00;
        chk("wr_s0_drop", {60'd0, s_rb, s_wb}, 64'd0);
        wait_ack("wr_s0", lat);
        chk("wr_s0_latency", 64'(lat), 64'd0);

        // Read slave 1; a stray ack from slave 0 first must be ignored.
        start(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
        mdl_rdata = 32'h1; mdl_rparity = 1'b1;
        push("rd_s1", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("rd_s1_strobe", {60'd0, s_rb, s_wb}, {60'd0, 2'b10, 2'b00});
        s_ack = 2'b01;
        @(negedge clock);
        chk("rd_s1_ignore_other", {60'd0, s_rb, s_wb}, {60'd0, 2'b10, 2'b00});
        s_ack = 2'b10; s1_rdata = 32'h1; s1_rparity = 1'b1;
        @(negedge clock);
        s_ack = 2'b00;
        wait_ack("rd_s1", lat);

        // Read slave 0 with bad read parity: perr, data forced to zero.
        start(1'b1, 1'b0, 8'h01, 32'h0, 1'b0);
        mdl_rdata = 32'h0; mdl_rparity = 1'b0;
        push("rd_s0_perr", 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("rd_s0_perr_strobe", {60'd0, s_rb, s_wb}, {60'd0, 2'b01, 2'b00});
        s_ack = 2'b01; s0_rdata = 32'h3; s0_rparity = 1'b1;
        @(negedge clock);
        s_ack = 2'b00;
        wait_ack("rd_s0_perr", lat);

        // Write with bad parity: no strobe, perr.
        start(1'b0, 1'b1, 8'h01, 32'h1, 1'b0);
        push("wr_perr", 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("wr_perr_nostrobe", {60'd0, s_rb, s_wb}, 64'd0);
        wait_ack("wr_perr", lat);

        // Unknown address: derr.
        start(1'b1, 1'b0, 8'h05, 32'h0, 1'b0);
        push("bad_addr", 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("bad_addr_nostrobe", {60'd0, s_rb, s_wb}, 64'd0);
        wait_ack("bad_addr", lat);

        // Read and write together: derr.
        start(1'b1, 1'b1, 8'h01, 32'h1, 1'b1);
        push("both_req", 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("both_req_nostrobe", {60'd0, s_rb, s_wb}, 64'd0);
        wait_ack("both_req", lat);

        // Good write to slave 1; read data must hold the previous value.
        start(1'b0, 1'b1, 8'h02, 32'h3, 1'b0);
        push("wr_s1", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("wr_s1_strobe", {60'd0, s_rb, s_wb}, {60'd0, 2'b00, 2'b10});
        s_ack = 2'b10;
        @(negedge clock);
        s_ack = 2'b00;
        wait_ack("wr_s1", lat);

        // Read slave 0 with no ack: strobe held exactly 16 cycles, then terr.
        start(1'b1, 1'b0, 8'h01, 32'h0, 1'b0);
        push("rd_timeout", 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        n = 0;
        while (s_rb == 2'b01 && n < 40) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_strobe_cycles", 64'(n), 64'd16);
        wait_ack("rd_timeout", lat);
        chk("timeout_ack_latency", 64'(lat), 64'd0);

        // Good read from slave 0.
        start(1'b1, 1'b0, 8'h01, 32'h0, 1'b0);
        mdl_rdata = 32'hA5A5_0000; mdl_rparity = 1'b0;
        push("rd_s0", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        s_ack = 2'b01; s0_rdata = 32'hA5A5_0000; s0_rparity = 1'b0;
        @(negedge clock);
        s_ack = 2'b00;
        wait_ack("rd_s0", lat);

        // Reset during ACCESS aborts silently; held request restarts afterwards.
        start(1'b1, 1'b0, 8'h02, 32'h0, 1'b0);
        @(negedge clock);
        chk("abort_strobe", {60'd0, s_rb, s_wb}, {60'd0, 2'b10, 2'b00});
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_cleared", {27'd0, m_ack, m_rdata, s_rb, s_wb}, 64'd0);
        mdl_rdata = 32'h0; mdl_rparity = 1'b0;
        reset_n = 1'b1;
        mdl_rdata = 32'h8000_0000; mdl_rparity = 1'b1;
        push("rd_after_reset", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("restart_strobe", {60'd0, s_rb, s_wb}, {60'd0, 2'b10, 2'b00});
        s_ack = 2'b10; s1_rdata = 32'h8000_0000; s1_rparity = 1'b1;
        @(negedge clock);
        s_ack = 2'b00;
        wait_ack("rd_after_reset", lat);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_bus_fabric.md
MAIN_BUS_FABRIC -- requirements
Module: main_bus_fabric

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_BUS_WIDTH, 32, data width.
- ADDR_BUS_WIDTH, 8, address width.
- SLAVE0_ID, 8'h01, slave 0 device ID.
- SLAVE1_ID, 8'h02, slave 1 device ID.
- TIMEOUT, 16, maximum cycles to wait for slave ack.

REQ-002 The block SHALL use one clock; reset is synchronous and active-low.

REQ-003 Ports (name, direction, width, meaning), one per line:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- m_rb  in  1  master read request, level, held until m_ack.
- m_wb  in  1  master write request, level, held until m_ack.
- m_addr  in  ADDR_BUS_WIDTH  target device ID.
- m_wdata  in  DATA_BUS_WIDTH  write data.
- m_wparity  in  1  write parity from master.
- m_ack  out  1  one-cycle completion strobe.
- m_rdata  out  DATA_BUS_WIDTH  read data.
- m_rparity  out  1  read parity.
- m_perr  out  1  parity error, valid with m_ack.
- m_derr  out  1  decode/protocol error, valid with m_ack.
- m_terr  out  1  timeout error, valid with m_ack.
- s_addr  out  ADDR_BUS_WIDTH  latched address.
- s_wdata  out  DATA_BUS_WIDTH  latched write data.
- s_wparity  out  1  latched write parity.
- s_rb  out  2  per-slave read strobe.
- s_wb  out  2  per-slave write strobe.
- s_ack  in  2  per-slave acknowledge.
- s0_rdata, s1_rdata  in  DATA_BUS_WIDTH  slave read data.
- s0_rparity, s1_rparity  in  1  slave read parity.

Function
REQ-004 Parity SHALL be even: the correct parity bit equals the XOR-reduction of the data word.
REQ-005 FSM states SHALL be IDLE, ACCESS, RESP and RELEASE; all outputs SHALL be registered.
REQ-006 IDLE SHALL sample m_rb/m_wb at each rising edge and take the first matching rule:
- both high: go to RESP with m_derr=1.
- m_addr matches neither ID: go to RESP with m_derr=1.
- write with m_wparity != ^m_wdata: go to RESP with m_perr=1; no slave is strobed.
- otherwise: latch addr/wdata/wparity onto s_*, assert the selected slave's s_rb or s_wb bit, and go to ACCESS.
REQ-007 ACCESS SHALL hold the strobe and s_* values stable and sample the selected slave's s_ack each cycle; ack from a non-selected slave SHALL be ignored.
REQ-008 On the selected s_ack=1 in ACCESS, the block SHALL drop the strobe next cycle and go to RESP.
- Read: capture that slave's rdata/rparity.
- If rparity != ^rdata, set m_perr=1 and force m_rdata to 0.
REQ-009 If TIMEOUT cycles elapse in ACCESS without ack, the block SHALL drop the strobe and go to RESP with m_terr=1.
REQ-010 RESP SHALL assert m_ack for exactly one cycle together with the error flags and read data, then go to RELEASE.
REQ-011 RELEASE SHALL return to IDLE only in a cycle where m_rb=0 and m_wb=0, so a held request never retriggers.
REQ-012 m_rdata/m_rparity SHALL hold their last value between accesses; error flags SHALL be 0 whenever m_ack=0.
REQ-013 Minimum latency: request sampled at edge N, strobe high after N, slave ack sampled at N+1, m_ack high after edge N+2.
REQ-014 At most one s_rb/s_wb bit SHALL be high at any time.

Reset
REQ-015 While reset_n=0 at a rising edge:
- state SHALL become IDLE and the timeout counter SHALL clear.
- all outputs (m_ack, m_rdata, m_rparity, m_perr, m_derr, m_terr, s_addr, s_wdata, s_wparity, s_rb, s_wb) SHALL become 0.
REQ-016 Reset asserted mid-access SHALL abort the transfer with no m_ack generated; a still-high request after reset release SHALL start a new transfer.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Write, m_addr=8'h01, m_wdata=32'h1, m_wparity=1: s_wb=2'b01, s_wdata=32'h1, s_wparity=1; slave 0 acks next cycle; m_ack one cycle, all errors 0.
- Read, m_addr=8'h02: s_rb=2'b10; s1_rdata=32'h1, s1_rparity=1 with ack; m_rdata=32'h1, m_rparity=1, m_perr=0.
- Read, m_addr=8'h01, s0_rdata=32'h3, s0_rparity=1: m_ack with m_perr=1, m_rdata=0.
- Write, m_wdata=32'h1, m_wparity=0: no strobe; m_ack with m_perr=1.
- m_addr=8'h05, or m_rb=m_wb=1: no strobe; m_ack with m_derr=1.
- Read to 8'h01 with no ack: strobe held 16 cycles, then m_ack with m_terr=1.
- reset_n low during ACCESS: strobes 0 next edge, no m_ack.
